// File: rtl/secded_ram_pkg.sv
// Shared definitions for the SECDED-protected RAM: codeword sizing, FSM states
// and the Hamming bit-position helpers used by the codec.
package secded_ram_pkg;

  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {StInit, StIdle, StRd, StWb} state_e;

  // Smallest P with 2**P >= w + P + 1.
  function automatic int unsigned calc_p(int unsigned w);
    int unsigned p = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((1 << p) < w + p + 1) p++;
    end
    return p;
  endfunction

  // Codeword width: data + Hamming check bits + overall parity.
  function automatic int unsigned calc_c(int unsigned w);
    return w + calc_p(w) + 1;
  endfunction

  function automatic logic is_pow2(int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword position of data bit i: the i-th non-power-of-two position >= 1.
  // Position 0 holds the overall parity bit.
  function automatic int unsigned data_pos(int unsigned i);
    int unsigned cnt = 0;
    for (int unsigned j = 1; j < 64; j++) begin
      if (!is_pow2(j)) begin
        if (cnt == i) return j;
        cnt++;
      end
    end
    return 0;
  endfunction

endpackage

// File: rtl/secded_codec.sv
// Combinational Hamming SECDED encoder/decoder. code_out is encode(data_in);
// data_out/err_* describe code_in.
module secded_codec
  import secded_ram_pkg::*;
#(
  parameter int unsigned W = 8,
  localparam int unsigned C = calc_c(W)
) (
  input  logic [W-1:0] data_in,
  input  logic [C-1:0] code_in,
  output logic [C-1:0] code_out,
  output logic [W-1:0] data_out,
  output logic         err_single,
  output logic         err_double
);

  // XOR of the positions of all set bits, parity bit excluded.
  function automatic int unsigned syndrome(logic [C-1:0] cw);
    int unsigned s = 0;
    for (int unsigned j = 1; j < C; j++) begin
      if (cw[j]) s ^= j;
    end
    return s;
  endfunction

  logic [C-1:0] placed;
  int unsigned  enc_syn;

  // Encoder: scatter data, fill check bits so the syndrome is zero, add parity.
  always_comb begin
    placed = '0;
    for (int unsigned i = 0; i < W; i++) placed[data_pos(i)] = data_in[i];
    enc_syn  = syndrome(placed);
    code_out = placed;
    for (int unsigned i = 0; (1 << i) < C; i++) code_out[1 << i] = enc_syn[i];
    code_out[0] = ^code_out[C-1:1];
  end

  logic [C-1:0] fixed;
  int unsigned  dec_syn;
  logic         par;

  // Decoder: classify, flip the single bad bit if correctable, gather data.
  always_comb begin
    dec_syn    = syndrome(code_in);
    par        = ^code_in;
    err_single = par && (dec_syn < C);
    err_double = (!par && (dec_syn != 0)) || (par && (dec_syn >= C));
    fixed      = code_in;
    for (int unsigned j = 0; j < C; j++) begin
      if (err_single && (dec_syn == j)) fixed[j] = ~code_in[j];
    end
    for (int unsigned i = 0; i < W; i++) data_out[i] = fixed[data_pos(i)];
  end

endmodule

// File: rtl/secded_ram.sv
// Single-port RAM with Hamming SECDED protection, self-initialisation,
// error injection on writes and scrub-on-correct writeback.
module secded_ram
  import secded_ram_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned C = calc_c(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [N-1:0]    addr,
  input  logic [W-1:0]    wdata,
  input  logic            inj_en,
  input  logic [C-1:0]    inj_mask,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [W-1:0]    rdata,
  output logic            err_corr,
  output logic            err_uncorr,
  output logic [CntW-1:0] corr_cnt,
  output logic [CntW-1:0] uncorr_cnt
);

  logic [C-1:0] mem [2**N];

  state_e       state_q;
  logic [N-1:0] init_addr_q;
  logic [N-1:0] rd_addr_q;
  logic [C-1:0] rd_code_q;

  logic [W-1:0] enc_data;
  logic [C-1:0] enc_code;
  logic [W-1:0] enc_unused_data;
  logic         enc_unused_single;
  logic         enc_unused_double;

  logic [W-1:0] dec_data;
  logic         dec_single;
  logic         dec_double;
  logic [C-1:0] dec_unused_code;

  logic         mem_we;
  logic [N-1:0] mem_waddr;
  logic [C-1:0] mem_wcode;

  secded_codec #(.W(W)) u_enc (
    .data_in    (enc_data),
    .code_in    ('0),
    .code_out   (enc_code),
    .data_out   (enc_unused_data),
    .err_single (enc_unused_single),
    .err_double (enc_unused_double)
  );

  secded_codec #(.W(W)) u_dec (
    .data_in    ('0),
    .code_in    (rd_code_q),
    .code_out   (dec_unused_code),
    .data_out   (dec_data),
    .err_single (dec_single),
    .err_double (dec_double)
  );

  assign req_ready = (state_q == StIdle);

  // Encoder source: zero during init, corrected read data during writeback.
  always_comb begin
    case (state_q)
      StInit:  enc_data = '0;
      StWb:    enc_data = rdata;
      default: enc_data = wdata;
    endcase
  end

  // Write port select; nothing is written on a reset edge.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wcode = enc_code;
    if (rst_n) begin
      case (state_q)
        StInit: begin
          mem_we    = 1'b1;
          mem_waddr = init_addr_q;
        end
        StIdle: begin
          if (req_valid && req_write) begin
            mem_we    = 1'b1;
            mem_wcode = enc_code ^ (inj_en ? inj_mask : '0);
          end
        end
        StWb: begin
          mem_we    = 1'b1;
          mem_waddr = rd_addr_q;
        end
        default: ;
      endcase
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wcode;
  end

  // Control FSM with registered response outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StInit;
      init_addr_q <= '0;
      rd_addr_q   <= '0;
      rd_code_q   <= '0;
      rsp_valid   <= 1'b0;
      rdata       <= '0;
      err_corr    <= 1'b0;
      err_uncorr  <= 1'b0;
      corr_cnt    <= '0;
      uncorr_cnt  <= '0;
    end else begin
      rsp_valid  <= 1'b0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      case (state_q)
        StInit: begin
          init_addr_q <= init_addr_q + N'(1);
          if (&init_addr_q) state_q <= StIdle;
        end
        StIdle: begin
          if (req_valid && !req_write) begin
            rd_code_q <= mem[addr];
            rd_addr_q <= addr;
            state_q   <= StRd;
          end
        end
        StRd: begin
          rsp_valid  <= 1'b1;
          rdata      <= dec_data;
          err_corr   <= dec_single;
          err_uncorr <= dec_double;
          if (dec_single && (corr_cnt != '1)) corr_cnt <= corr_cnt + CntW'(1);
          if (dec_double && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CntW'(1);
          state_q <= dec_single ? StWb : StIdle;
        end
        StWb: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_ram.sv
// Directed self-checking bench for secded_ram (N=4, W=8, C=13).
module tb_secded_ram;

  localparam int N = 4;
  localparam int W = 8;
  localparam int C = 13;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_write;
  logic [N-1:0] addr;
  logic [W-1:0] wdata;
  logic         inj_en;
  logic [C-1:0] inj_mask;
  logic         req_ready;
  logic         rsp_valid;
  logic [W-1:0] rdata;
  logic         err_corr;
  logic         err_uncorr;
  logic [7:0]   corr_cnt;
  logic [7:0]   uncorr_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Results of the last do_read.
  logic [W-1:0] rd_d;
  logic         rd_c;
  logic         rd_u;
  logic         rd_rdy;
  int           rd_lat;

  secded_ram #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .addr       (addr),
    .wdata      (wdata),
    .inj_en     (inj_en),
    .inj_mask   (inj_mask),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rdata      (rdata),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got req_ready=0 want 1 within 100 cycles");
    end
  endtask

  task automatic do_write(input logic [N-1:0] a, input logic [W-1:0] d, input logic ie,
                          input logic [C-1:0] m);
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    addr      = a;
    wdata     = d;
    inj_en    = ie;
    inj_mask  = m;
    tick();
    req_valid = 1'b0;
    inj_en    = 1'b0;
    inj_mask  = '0;
  endtask

  task automatic do_read(input logic [N-1:0] a);
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    addr      = a;
    tick();
    req_valid = 1'b0;
    rd_lat    = 1;
    while (!rsp_valid && rd_lat < 10) begin
      tick();
      rd_lat++;
    end
    rd_d   = rdata;
    rd_c   = err_corr;
    rd_u   = err_uncorr;
    rd_rdy = req_ready;
  endtask

  task automatic count_init(input string tag);
    int n = 0;
    while (!req_ready && n < 40) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL %s_init_cycles: got %0d want 16", tag, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({req_ready, rsp_valid, err_corr, err_uncorr} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000", {req_ready, rsp_valid, err_corr, err_uncorr});
    end
    vectors++;
    if ({rdata, corr_cnt, uncorr_cnt} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_values: got %h want 000000", {rdata, corr_cnt, uncorr_cnt});
    end
    rst_n = 1'b1;
    // Write held during INIT must be ignored; dropped once ready rises.
    req_valid = 1'b1;
    req_write = 1'b1;
    addr      = 4'd9;
    wdata     = 8'h77;
    count_init("reset");
    do_read(4'd3);
    vectors++;
    if (rd_lat !== 2) begin
      miscompares++;
      $display("FAIL read_latency: got %0d want 2", rd_lat);
    end
    vectors++;
    if ({rd_d, rd_c, rd_u} !== 10'h0) begin
      miscompares++;
      $display("FAIL init_read3: got data=%h c=%b u=%b want 00 0 0", rd_d, rd_c, rd_u);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_one_cycle: got rsp_valid=%b want 0", rsp_valid);
    end
    do_read(4'd9);
    vectors++;
    if (rd_d !== 8'h00) begin
      miscompares++;
      $display("FAIL ignored_write: got %h want 00", rd_d);
    end
  endtask

  task automatic test_write_read();
    do_write(4'd5, 8'hA5, 1'b0, '0);
    do_read(4'd5);
    vectors++;
    if ({rd_d, rd_c, rd_u, rd_rdy} !== {8'hA5, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL clean_read: got data=%h c=%b u=%b rdy=%b want a5 0 0 1",
               rd_d, rd_c, rd_u, rd_rdy);
    end
    vectors++;
    if ({corr_cnt, uncorr_cnt} !== 16'h0) begin
      miscompares++;
      $display("FAIL clean_counters: got %h want 0000", {corr_cnt, uncorr_cnt});
    end
  endtask

  task automatic test_single();
    do_write(4'd2, 8'h3C, 1'b1, 13'h0040);
    do_read(4'd2);
    vectors++;
    if ({rd_d, rd_c, rd_u, rd_rdy} !== {8'h3C, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_read: got data=%h c=%b u=%b rdy=%b want 3c 1 0 0",
               rd_d, rd_c, rd_u, rd_rdy);
    end
    vectors++;
    if (corr_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL single_cnt: got %0d want 1", corr_cnt);
    end
    tick();
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wb_one_cycle: got req_ready=%b want 1", req_ready);
    end
    do_read(4'd2);
    vectors++;
    if ({rd_d, rd_c, rd_u, corr_cnt} !== {8'h3C, 1'b0, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL scrubbed_reread: got data=%h c=%b u=%b cnt=%0d want 3c 0 0 1",
               rd_d, rd_c, rd_u, corr_cnt);
    end
    // Error on the overall parity bit itself.
    do_write(4'd4, 8'hFF, 1'b1, 13'h0001);
    do_read(4'd4);
    vectors++;
    if ({rd_d, rd_c, rd_u, corr_cnt} !== {8'hFF, 1'b1, 1'b0, 8'd2}) begin
      miscompares++;
      $display("FAIL parity_bit_err: got data=%h c=%b u=%b cnt=%0d want ff 1 0 2",
               rd_d, rd_c, rd_u, corr_cnt);
    end
    // Error on the highest codeword position (data bit 7).
    do_write(4'd6, 8'h01, 1'b1, 13'h1000);
    do_read(4'd6);
    vectors++;
    if ({rd_d, rd_c, rd_u, corr_cnt} !== {8'h01, 1'b1, 1'b0, 8'd3}) begin
      miscompares++;
      $display("FAIL top_bit_err: got data=%h c=%b u=%b cnt=%0d want 01 1 0 3",
               rd_d, rd_c, rd_u, corr_cnt);
    end
  endtask

  task automatic test_double();
    // Positions 2 (check) and 9 (data bit 4): raw data reads back 0x2C.
    do_write(4'd7, 8'h3C, 1'b1, 13'h0204);
    do_read(4'd7);
    vectors++;
    if ({rd_d, rd_c, rd_u, rd_rdy, uncorr_cnt} !== {8'h2C, 1'b0, 1'b1, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL double_read: got data=%h c=%b u=%b rdy=%b cnt=%0d want 2c 0 1 1 1",
               rd_d, rd_c, rd_u, rd_rdy, uncorr_cnt);
    end
    do_read(4'd7);
    vectors++;
    if ({rd_d, rd_u, uncorr_cnt, corr_cnt} !== {8'h2C, 1'b1, 8'd2, 8'd3}) begin
      miscompares++;
      $display("FAIL double_reread: got data=%h u=%b ucnt=%0d ccnt=%0d want 2c 1 2 3",
               rd_d, rd_u, uncorr_cnt, corr_cnt);
    end
    // Three flips at 1,4,8: parity mismatch with syndrome 13 > C-1.
    do_write(4'd8, 8'h5A, 1'b1, 13'h0112);
    do_read(4'd8);
    vectors++;
    if ({rd_d, rd_c, rd_u, uncorr_cnt} !== {8'h5A, 1'b0, 1'b1, 8'd3}) begin
      miscompares++;
      $display("FAIL syndrome_oob: got data=%h c=%b u=%b cnt=%0d want 5a 0 1 3",
               rd_d, rd_c, rd_u, uncorr_cnt);
    end
  endtask

  task automatic test_saturate();
    int exp_cnt = 3;
    logic [C-1:0] m;
    for (int i = 0; i < 260; i++) begin
      m = '0;
      m[i % 13] = 1'b1;
      do_write(4'(i % 16), 8'h69, 1'b1, m);
      do_read(4'(i % 16));
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      vectors++;
      if ({rd_d, rd_c, corr_cnt} !== {8'h69, 1'b1, 8'(exp_cnt)}) begin
        miscompares++;
        $display("FAIL sat_iter%0d: got data=%h c=%b cnt=%0d want 69 1 %0d",
                 i, rd_d, rd_c, corr_cnt, exp_cnt);
      end
    end
    vectors++;
    if (corr_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_final: got %0d want 255", corr_cnt);
    end
  endtask

  task automatic test_reset_in_wb();
    do_write(4'd2, 8'h3C, 1'b1, 13'h0040);
    do_read(4'd2);
    vectors++;
    if (rd_c !== 1'b1) begin
      miscompares++;
      $display("FAIL wb_setup: got err_corr=%b want 1", rd_c);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({rsp_valid, req_ready, corr_cnt, uncorr_cnt} !== 18'h0) begin
      miscompares++;
      $display("FAIL wb_reset: got rsp=%b rdy=%b ccnt=%0d ucnt=%0d want 0 0 0 0",
               rsp_valid, req_ready, corr_cnt, uncorr_cnt);
    end
    rst_n = 1'b1;
    count_init("wb_reset");
    do_read(4'd2);
    vectors++;
    if ({rd_d, rd_c, rd_u} !== 10'h0) begin
      miscompares++;
      $display("FAIL wb_reset_read: got data=%h c=%b u=%b want 00 0 0", rd_d, rd_c, rd_u);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    inj_en    = 1'b0;
    inj_mask  = '0;
    test_reset();
    test_write_read();
    test_single();
    test_double();
    test_saturate();
    test_reset_in_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/secded_ram.md
SECDED_RAM -- requirements
Module: secded_ram

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N  4  address width; depth 2**N words.
- W  8  data width; P = smallest integer with 2**P >= W+P+1; codeword width C = W+P+1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_write  in  1  1 = write, 0 = read.
- addr  in  N  word address.
- wdata  in  W  write data.
- inj_en  in  1  enables error injection on this write.
- inj_mask  in  C  codeword bits flipped on injected write.
- req_ready  out  1  request accepted when req_valid and req_ready are both high at a rising edge.
- rsp_valid  out  1  one-cycle read-response strobe.
- rdata  out  W  read data, qualified by rsp_valid.
- err_corr  out  1  single error corrected (with rsp_valid).
- err_uncorr  out  1  double error detected, not corrected (with rsp_valid).
- corr_cnt  out  8  saturating count of corrected reads.
- uncorr_cnt  out  8  saturating count of uncorrectable reads.

Function
REQ-003 Storage SHALL be a 2**N x C array holding Hamming-SECDED codewords: P check bits at power-of-two positions, plus one overall parity bit.
REQ-004 The FSM SHALL have states INIT, IDLE, RD and WB; req_ready SHALL be high only in IDLE.
REQ-005 INIT SHALL write encode(0) to addresses 0..2**N-1, one per cycle, in ascending order; after the last address it SHALL go to IDLE.
REQ-006 An accepted write SHALL store encode(wdata) XOR (inj_en ? inj_mask : 0) at that edge; the FSM SHALL stay in IDLE (one write per cycle).
REQ-007 An accepted read at edge E0 SHALL register mem[addr] and enter RD; at E1 rdata, err_corr, err_uncorr and rsp_valid SHALL be registered, giving a latency of 2 edges.
REQ-008 Decode, syndrome s, overall parity mismatch p: s=0,p=0 -> clean; p=1 -> single error (s=0 means the parity bit itself); s!=0,p=0 -> uncorrectable; p=1 with s>C-1 -> uncorrectable.
REQ-009 On a single error, rdata SHALL be the corrected data; err_corr=1; corr_cnt SHALL increment; the FSM SHALL go RD->WB and, at the next edge, write the corrected codeword back to the same address, then return to IDLE.
REQ-010 On an uncorrectable error, rdata SHALL be the raw stored data bits; err_uncorr=1; uncorr_cnt SHALL increment; there SHALL be no writeback; RD->IDLE.
REQ-011 A clean read SHALL go RD->IDLE with err_corr=err_uncorr=0.
REQ-012 Both counters SHALL saturate at 255 and never wrap.
REQ-013 Requests presented while req_ready=0 SHALL be ignored; the requester holds them.
REQ-014 rsp_valid, err_corr and err_uncorr SHALL be high for exactly one cycle per read and low otherwise.

Reset
REQ-015 While rst_n=0 at an edge: FSM SHALL be INIT with init address 0; req_ready=0, rsp_valid=0, err_corr=0, err_uncorr=0, rdata=0, corr_cnt=0, uncorr_cnt=0.
REQ-016 Reset in RD or WB SHALL drop the pending response or writeback; array contents are then overwritten by INIT.

Structure
REQ-017 A shared package SHALL hold the parity-width function P(W), codeword width, FSM state enumeration and counter width (8).
REQ-018 Encode and decode SHALL be one combinational sub-module, secded_codec, instantiated once for encode and once for decode.

Verification (N=4, W=8, C=13)
REQ-019 Release reset -> req_ready low exactly 16 cycles, then high; read addr 3 -> rsp_valid 2 edges after accept, rdata=0x00, no error flags.
REQ-020 Write 0xA5 to addr 5, then read addr 5 -> rdata=0xA5, err_corr=0, err_uncorr=0, counters 0.
REQ-021 Write 0x3C to addr 2 with inj_mask bit 6 -> read gives 0x3C, err_corr=1, corr_cnt=1, req_ready low one extra cycle (WB); reread -> clean, corr_cnt stays 1.
REQ-022 Write 0x3C to addr 7 with inj_mask bits 2 and 9 -> read gives err_uncorr=1, uncorr_cnt=1; reread -> err_uncorr=1, uncorr_cnt=2.
REQ-023 Perform 260 single-error inject/read pairs -> corr_cnt=255, never 0 after the first.
REQ-024 Assert rst_n=0 during WB -> no rsp_valid, counters 0, INIT repeats 16 cycles, then the read of addr 2 returns 0x00.
